// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared state and PC-source encodings for the pipeline hazard controller
package hazard_ctrl_pkg;
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_MWAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] RS_SEQ   = 2'd0;
    localparam logic [1:0] RS_BR    = 2'd1;
    localparam logic [1:0] RS_EXC   = 2'd2;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: saturating up-counter, clk/rst/inc in, cnt out, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk)
        cnt <= rst ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: per-latch hold/flush, PC source select and stall counters from load-use, mem-busy, interrupt and branch events
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             LoadUse,
    input  logic             MemBusy,
    input  logic             IntReq,
    input  logic             BranchTaken,
    output logic             PCHold,
    output logic             IFIDHold,
    output logic             IDEXHold,
    output logic             EXMEMHold,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             EXMEMFlush,
    output logic             MEMWBFlush,
    output logic [1:0]       RedirectSel,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] LoadUseCount,
    output logic [1:0]       State
);
    logic [1:0] st, nxt;
    logic       ev_int, ev_mem, ev_lu, ev_br, in_flush;
    // MWAIT reacts to inputs exactly like RUN once priority is applied; only FLUSH adds the stale-fetch kill
    assign ev_int   = IntReq;
    assign ev_mem   = !IntReq && MemBusy;
    assign ev_lu    = !IntReq && !MemBusy && LoadUse;
    assign ev_br    = !IntReq && !MemBusy && !LoadUse && BranchTaken;
    assign in_flush = st == ST_FLUSH;
    assign State    = st;
    always_ff @(posedge clk)
        st <= rst ? ST_RUN : nxt;
    always_comb
        nxt = (ev_int || ev_br) ? ST_FLUSH : ev_mem ? ST_MWAIT : ST_RUN;
    always_comb begin
        PCHold      = !rst && (ev_mem || ev_lu);
        IFIDFlush   = rst || ev_int || ev_br || in_flush;
        IFIDHold    = !IFIDFlush && (ev_mem || ev_lu);
        IDEXHold    = !rst && (ev_mem || ev_lu);
        EXMEMHold   = !rst && ev_mem;
        IDEXFlush   = rst || ev_int || ev_br;
        EXMEMFlush  = rst || ev_int || ev_lu;
        MEMWBFlush  = rst || ev_mem;
        RedirectSel = rst ? RS_SEQ : ev_int ? RS_EXC : ev_br ? RS_BR : RS_SEQ;
    end
    sat_counter #(.CNT_W(CNT_W)) u_stall (.clk(clk), .rst(rst), .inc(PCHold), .cnt(StallCount));
    sat_counter #(.CNT_W(CNT_W)) u_lu    (.clk(clk), .rst(rst), .inc(ev_lu),  .cnt(LoadUseCount));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl at CNT_W=32 and CNT_W=4
module tb_hazard_ctrl;
    localparam logic [7:0] H_PC = 8'h80, H_IFID = 8'h40, H_IDEX = 8'h20, H_EXMEM = 8'h10;
    localparam logic [7:0] F_IFID = 8'h08, F_IDEX = 8'h04, F_EXMEM = 8'h02, F_MEMWB = 8'h01;
    localparam logic [7:0] C_MB = H_PC | H_IFID | H_IDEX | H_EXMEM | F_MEMWB;
    localparam logic [7:0] C_LU = H_PC | H_IFID | H_IDEX | F_EXMEM;
    localparam logic [7:0] C_BR = F_IFID | F_IDEX;
    localparam logic [7:0] C_INT = F_IFID | F_IDEX | F_EXMEM;
    localparam logic [7:0] C_RST = F_IFID | F_IDEX | F_EXMEM | F_MEMWB;
    typedef struct {
        string       tag;
        logic [7:0]  ctl;
        logic [1:0]  rs;
        logic [1:0]  st;
        int          sc;
        int          lc;
    } exp_t;
    exp_t sbq[$];
    int checks = 0, failures = 0;
    logic clk = 0, rst = 1, LoadUse = 0, MemBusy = 0, IntReq = 0, BranchTaken = 0;
    logic PCHold, IFIDHold, IDEXHold, EXMEMHold, IFIDFlush, IDEXFlush, EXMEMFlush, MEMWBFlush;
    logic [1:0] RedirectSel, State;
    logic [31:0] StallCount, LoadUseCount;
    logic a4, b4, c4, d4, e4, f4, g4, h4;
    logic [1:0] rs4, st4;
    logic [3:0] sc4, lc4;
    always #5 clk = ~clk;
    hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .LoadUse(LoadUse), .MemBusy(MemBusy), .IntReq(IntReq), .BranchTaken(BranchTaken),
        .PCHold(PCHold), .IFIDHold(IFIDHold), .IDEXHold(IDEXHold), .EXMEMHold(EXMEMHold),
        .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .EXMEMFlush(EXMEMFlush), .MEMWBFlush(MEMWBFlush),
        .RedirectSel(RedirectSel), .StallCount(StallCount), .LoadUseCount(LoadUseCount), .State(State)
    );
    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .LoadUse(LoadUse), .MemBusy(MemBusy), .IntReq(IntReq), .BranchTaken(BranchTaken),
        .PCHold(a4), .IFIDHold(b4), .IDEXHold(c4), .EXMEMHold(d4),
        .IFIDFlush(e4), .IDEXFlush(f4), .EXMEMFlush(g4), .MEMWBFlush(h4),
        .RedirectSel(rs4), .StallCount(sc4), .LoadUseCount(lc4), .State(st4)
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step(input string tag, input logic r, input logic lu, input logic mb, input logic ir,
                        input logic bt, input logic [7:0] ctl, input logic [1:0] rs, input logic [1:0] st,
                        input int sc, input int lc);
        exp_t e;
        rst = r; LoadUse = lu; MemBusy = mb; IntReq = ir; BranchTaken = bt;
        e.tag = tag; e.ctl = ctl; e.rs = rs; e.st = st; e.sc = sc; e.lc = lc;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        chk({e.tag, ".ctl"}, {56'd0, PCHold, IFIDHold, IDEXHold, EXMEMHold, IFIDFlush, IDEXFlush, EXMEMFlush, MEMWBFlush}, {56'd0, e.ctl});
        chk({e.tag, ".rs"}, {62'd0, RedirectSel}, {62'd0, e.rs});
        chk({e.tag, ".state"}, {62'd0, State}, {62'd0, e.st});
        chk({e.tag, ".stall"}, {32'd0, StallCount}, {32'd0, e.sc});
        chk({e.tag, ".lu"}, {32'd0, LoadUseCount}, {32'd0, e.lc});
        chk({e.tag, ".stall4"}, {60'd0, sc4}, 64'(e.sc > 15 ? 15 : e.sc));
        chk({e.tag, ".state4"}, {62'd0, st4}, {62'd0, e.st});
        @(posedge clk);
        #1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        repeat (2) @(posedge clk);
        #1;
        step("rst",      1, 0, 0, 0, 0, C_RST, 0, 0, 0, 0);
        step("idle",     0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        step("lu_br",    0, 1, 0, 0, 1, C_LU,  0, 0, 0, 0);
        step("lu_after", 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 1);
        step("mb1",      0, 0, 1, 0, 0, C_MB,  0, 0, 1, 1);
        step("mb2",      0, 0, 1, 0, 0, C_MB,  0, 1, 2, 1);
        step("mb3",      0, 1, 1, 0, 1, C_MB,  0, 1, 3, 1);
        step("mb_rel_lu",0, 1, 0, 0, 0, C_LU,  0, 1, 4, 1);
        step("mb_done",  0, 0, 0, 0, 0, 8'h00, 0, 0, 5, 2);
        step("br",       0, 0, 0, 0, 1, C_BR,  1, 0, 5, 2);
        step("br_flush", 0, 0, 0, 0, 0, F_IFID,0, 2, 5, 2);
        step("br_run",   0, 0, 0, 0, 0, 8'h00, 0, 0, 5, 2);
        step("mw_enter", 0, 0, 1, 0, 0, C_MB,  0, 0, 5, 2);
        step("mw_int",   0, 1, 1, 1, 0, C_INT, 2, 1, 6, 2);
        step("int_fl",   0, 0, 0, 0, 0, F_IFID,0, 2, 6, 2);
        step("int_lu",   0, 1, 0, 1, 0, C_INT, 2, 0, 6, 2);
        step("int_lu_fl",0, 0, 0, 0, 0, F_IFID,0, 2, 6, 2);
        step("br2",      0, 0, 0, 0, 1, C_BR,  1, 0, 6, 2);
        step("fl_mb",    0, 0, 1, 0, 0, (C_MB & ~H_IFID) | F_IFID, 0, 2, 6, 2);
        step("fl_mb_rel",0, 0, 0, 0, 0, 8'h00, 0, 1, 7, 2);
        step("br3",      0, 0, 0, 0, 1, C_BR,  1, 0, 7, 2);
        step("fl_lu",    0, 1, 0, 0, 1, C_LU & ~H_IFID | F_IFID, 0, 2, 7, 2);
        step("fl_lu_run",0, 0, 0, 0, 0, 8'h00, 0, 0, 8, 3);
        step("rst2",     1, 0, 0, 0, 0, C_RST, 0, 0, 8, 3);
        for (int i = 0; i < 20; i++)
            step($sformatf("sat%0d", i), 0, 0, 1, 0, 0, C_MB, 0, (i == 0) ? 2'd0 : 2'd1, i, 0);
        step("rst_mw",   1, 0, 1, 0, 0, C_RST, 0, 1, 20, 0);
        step("post_rst", 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
